// File: rtl/inst_queue_param.sv
// Instruction queue between fetch and decode/issue: up to ENQ_W packets in and
// DEQ_W oldest packets out per cycle, with flush on redirect and fetch back-pressure.
module inst_queue_param #(
  parameter int ENQ_W     = 4,
  parameter int DEQ_W     = 2,
  parameter int DEPTH     = 16,
  parameter int PAYLOAD_W = 128,
  parameter int STOP_GAP  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          enq_valid_i,
  input  logic [ENQ_W-1:0]              enq_mask_i,
  input  logic [ENQ_W*PAYLOAD_W-1:0]    enq_data_i,
  output logic                          enq_ready_o,
  input  logic [$clog2(DEQ_W+1)-1:0]    deq_num_i,
  output logic [DEQ_W-1:0]              deq_valid_o,
  output logic [DEQ_W*PAYLOAD_W-1:0]    deq_data_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic                          stop_fetch_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW:0] DEPTH_C  = (PW+1)'(DEPTH);
  localparam logic [PW:0] READY_TH = (PW+1)'(ENQ_W);
  localparam logic [PW:0] STOP_TH  = (PW+1)'(ENQ_W + STOP_GAP);

  logic [PAYLOAD_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]        count, n_enq, n_deq, deq_avail, deq_req;
  logic [PW:0]          free;
  logic                 enq_fire;
  logic                 seen_zero;

  // Pointers carry an extra wrap bit so full and empty stay distinguishable.
  assign count        = tail_q - head_q;
  assign free         = DEPTH_C - {1'b0, count};
  assign count_o      = count;
  assign empty_o      = (count == '0);
  assign full_o       = (count == PW'(DEPTH));
  assign enq_ready_o  = (free >= READY_TH);
  assign stop_fetch_o = (free < STOP_TH);
  assign enq_fire     = enq_valid_i & enq_ready_o & ~flush_i;

  always_comb begin
    n_enq     = '0;
    seen_zero = 1'b0;
    for (int k = 0; k < ENQ_W; k++) begin
      if (!enq_mask_i[k]) seen_zero = 1'b1;
      else if (!seen_zero) n_enq = PW'(k + 1);
    end
  end

  assign deq_avail = (count > PW'(DEQ_W)) ? PW'(DEQ_W) : count;
  assign deq_req   = (PW'(deq_num_i) > PW'(DEQ_W)) ? PW'(DEQ_W) : PW'(deq_num_i);
  assign n_deq     = (deq_req < deq_avail) ? deq_req : deq_avail;

  always_comb begin
    head_d = head_q + n_deq;
    tail_d = enq_fire ? (tail_q + n_enq) : tail_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (enq_fire && !rst) begin
      for (int k = 0; k < ENQ_W; k++) begin
        if (PW'(k) < n_enq)
          mem_q[tail_q[IW-1:0] + IW'(k)] <= enq_data_i[k*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  always_comb begin
    deq_valid_o = '0;
    deq_data_o  = '0;
    for (int k = 0; k < DEQ_W; k++) begin
      if (count > PW'(k)) begin
        deq_valid_o[k]                      = 1'b1;
        deq_data_o[k*PAYLOAD_W +: PAYLOAD_W] = mem_q[head_q[IW-1:0] + IW'(k)];
      end
    end
  end
endmodule

// File: doc/inst_queue_param.md
Name: inst_queue_param

Overview:
- Parametrised instruction queue between fetch and decode/issue.
- Accepts up to ENQ_W fetched instruction packets per cycle.
- Presents up to DEQ_W oldest packets to the issue logic each cycle, with count-based dequeue.
- Adds capabilities the fixed 4-in/2-out queue lacks: generic width, depth and lane count, single-cycle flush on redirect, an explicit enqueue ready, and a dequeue clamp.

Parameters:
- ENQ_W, 4, enqueue lanes per cycle (1..8).
- DEQ_W, 2, dequeue lanes per cycle (1..4, ≤ DEPTH).
- DEPTH, 16, entries; power of two, ≥ ENQ_W+DEQ_W.
- PAYLOAD_W, 128, bits per entry (PC, inst, prediction, exception fields packed by the caller).
- STOP_GAP, 4, slack entries reserved for fetches already in flight.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- flush_i  in  1  discard all entries (branch/exception redirect).
- enq_valid_i  in  1  enqueue request.
- enq_mask_i  in  ENQ_W  per-lane valid; lane 0 is the oldest.
- enq_data_i  in  ENQ_W*PAYLOAD_W  lane k occupies bits [k*PAYLOAD_W +: PAYLOAD_W].
- enq_ready_o  out  1  free entries ≥ ENQ_W.
- deq_num_i  in  $clog2(DEQ_W+1)  entries consumed this cycle.
- deq_valid_o  out  DEQ_W  lane k valid when count > k.
- deq_data_o  out  DEQ_W*PAYLOAD_W  entry at head+k.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- empty_o  out  1  count == 0.
- full_o  out  1  count == DEPTH.
- stop_fetch_o  out  1  free < ENQ_W+STOP_GAP.

Behaviour:
- Storage and pointers:
  - Storage is a DEPTH×PAYLOAD_W register array.
  - head and tail are $clog2(DEPTH)+1 bits wide, with an extra wrap bit.
  - count = tail-head, computed modulo 2^(log2 DEPTH+1).
  - Array index = pointer[log2 DEPTH-1:0]; index wrap-around is natural.
- Reset (async, rst=1):
  - head=tail=0, so count_o=0, empty_o=1, full_o=0, enq_ready_o=1, stop_fetch_o=0, deq_valid_o=0, deq_data_o=0.
  - Storage array is not reset.
  - Reset asserted mid-operation drops all content immediately; no partial write completes.
- Enqueue:
  - Fires when enq_valid_i & enq_ready_o & !flush_i.
  - n_enq = number of trailing ones in enq_mask_i. Bits above the first zero are ignored (mask must be contiguous).
  - Lane k (k<n_enq) is written to index tail+k. tail += n_enq at the clock edge.
  - enq_valid_i while enq_ready_o=0: nothing is written, tail is unchanged, and the producer holds its data.
  - enq_ready_o uses the pre-dequeue count. No credit is taken from a same-cycle dequeue.
- Dequeue:
  - Combinational read: deq_data_o lane k = mem[head+k] when deq_valid_o[k], else 0.
  - n_deq = min(deq_num_i, popcount(deq_valid_o)). The clamp ignores over-requests with no error.
  - head += n_deq at the clock edge. deq_num_i > DEQ_W is treated as DEQ_W.
- Latency and concurrency:
  - An entry written at edge N is visible on deq_valid_o/deq_data_o after edge N. There is no enqueue-to-dequeue bypass.
  - Enqueue and dequeue in the same cycle are both applied: count' = count + n_enq - n_deq.
- Flush:
  - flush_i=1 at edge N sets head=tail=0 and ignores that cycle's enqueue and dequeue.
  - Outputs show empty after edge N. flush_i has priority over everything except rst.
- Status flags: full_o, empty_o, count_o and stop_fetch_o are combinational from head and tail (registered-pointer based, glitch-free at the edge).
- Full boundary: at count==DEPTH, enq_ready_o=0 and the wrap bits differ with equal indices. Nothing is overwritten.

Test Plan:
- Reset, then enq mask 4'b1111, data A0..A3 -> next cycle count_o=4, deq_valid_o=2'b11, deq_data_o={A1,A0}; deq_num_i=2 -> then {A3,A2}, count_o=2.
- Fill to 16 with four enqueues of 4'b1111 -> full_o=1, enq_ready_o=0, stop_fetch_o=1; further enq_valid_i changes nothing; one deq_num_i=2 -> count_o=14, enq_ready_o=0 (free 2 < 4).
- Wrap: 10 cycles of enq 4'b0011 with deq_num_i=2 -> head/tail pass index 15→0, data order preserved, count_o stays 2.
- enq_mask_i=4'b1011 -> only 2 entries are written (lanes 0,1); mask 4'b0000 with enq_valid_i=1 -> count unchanged.
- count_o=1, deq_num_i=2 -> clamped: count_o=0, empty_o=1, head advances by 1.
- count_o=9, flush_i=1 with simultaneous enq 4'b1111 and deq_num_i=2 -> next cycle count_o=0, empty_o=1, deq_valid_o=0; rst pulsed mid-fill asynchronously -> outputs at reset values before the next edge.
